// File: rtl/nios_multi_timer_pkg.sv
// Shared constants for the multi-channel interval timer.
// Register offsets, STATUS/CONTROL bit positions, prescaler field.
package nios_multi_timer_pkg;

  localparam logic [1:0] REG_STATUS   = 2'd0;
  localparam logic [1:0] REG_CONTROL  = 2'd1;
  localparam logic [1:0] REG_PERIOD   = 2'd2;
  localparam logic [1:0] REG_SNAPSHOT = 2'd3;

  localparam int STAT_TO  = 0;
  localparam int STAT_RUN = 1;

  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;

  localparam int PRESC_LSB = 8;
  localparam int PRESC_W   = 8;

endpackage

// File: rtl/nios_multi_timer_ch.sv
// One timer channel: period, down-counter, RUN/TO, CONTROL, snapshot.
// NIOS_MULTI_TIMER_PRESCALER_EN adds a per-channel tick prescaler.
module nios_multi_timer_ch
  import nios_multi_timer_pkg::*;
#(
  parameter int          COUNT_W    = 32,
  parameter logic [31:0] PERIOD_RST = 32'd99999
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             we_i,
  input  logic [1:0]       reg_i,
  input  logic [31:0]      wdata_i,
  output logic             irq_o,
  output logic [3:0][31:0] rd_o
);

  localparam logic [COUNT_W-1:0] P_RST =
    PERIOD_RST[COUNT_W-1:0];

  logic [COUNT_W-1:0] per_q, per_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic [COUNT_W-1:0] snap_q, snap_d;
  logic run_q, run_d;
  logic to_q, to_d;
  logic ito_q, ito_d;
  logic cont_q, cont_d;
  logic ld_q, ld_d;

  logic wr_stat, wr_ctrl, wr_per, wr_snap;
  logic start, stop, tick, expire;
  logic [PRESC_W-1:0] presc_rd;
  logic unused_w;

  assign unused_w = ^wdata_i;

  // Which register of this channel a write targets
  always_comb begin
    wr_stat = 1'b0;
    wr_ctrl = 1'b0;
    wr_per  = 1'b0;
    wr_snap = 1'b0;
    if (we_i) begin
      unique case (reg_i)
        REG_STATUS:   wr_stat = 1'b1;
        REG_CONTROL:  wr_ctrl = 1'b1;
        REG_PERIOD:   wr_per  = 1'b1;
        REG_SNAPSHOT: wr_snap = 1'b1;
        default: ;
      endcase
    end
  end

  assign start = wr_ctrl & wdata_i[CTRL_START];
  assign stop  = wr_ctrl & wdata_i[CTRL_STOP];

  // A pending period reload pre-empts counting on its edge
  assign expire = run_q & tick & ~ld_q &
                  (cnt_q == '0);

`ifdef NIOS_MULTI_TIMER_PRESCALER_EN
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [PRESC_W-1:0] pcnt_q, pcnt_d;

  assign tick     = (pcnt_q == presc_q);
  assign presc_rd = presc_q;

  // Prescale divider restarts on start, reload and timeout
  always_comb begin
    presc_d = presc_q;
    pcnt_d  = pcnt_q;
    if (wr_ctrl)
      presc_d = wdata_i[PRESC_LSB +: PRESC_W];
    if (run_q)
      pcnt_d = tick ? '0 : pcnt_q + PRESC_W'(1);
    if (start || ld_q || expire)
      pcnt_d = '0;
  end

  // Prescaler registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q <= '0;
      pcnt_q  <= '0;
    end else begin
      presc_q <= presc_d;
      pcnt_q  <= pcnt_d;
    end
  end
`else
  assign tick     = 1'b1;
  assign presc_rd = '0;
`endif

  // Counter, run/timeout and register next-state
  always_comb begin
    per_d  = per_q;
    cnt_d  = cnt_q;
    snap_d = snap_q;
    run_d  = run_q;
    to_d   = to_q;
    ito_d  = ito_q;
    cont_d = cont_q;
    ld_d   = wr_per;

    if (ld_q) begin
      cnt_d = per_q;
      run_d = 1'b0;
    end else if (run_q && tick) begin
      if (cnt_q == '0) begin
        cnt_d = per_q;
        if (!cont_q)
          run_d = 1'b0;
      end else begin
        cnt_d = cnt_q - COUNT_W'(1);
      end
    end

    if (stop)
      run_d = 1'b0;
    if (start)
      run_d = 1'b1;

    if (wr_stat && wdata_i[STAT_TO])
      to_d = 1'b0;
    if (expire)
      to_d = 1'b1;

    if (wr_ctrl) begin
      ito_d  = wdata_i[CTRL_ITO];
      cont_d = wdata_i[CTRL_CONT];
    end
    if (wr_per)
      per_d = wdata_i[COUNT_W-1:0];
    if (wr_snap)
      snap_d = cnt_q;
  end

  // Channel state registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      per_q  <= P_RST;
      cnt_q  <= P_RST;
      snap_q <= '0;
      run_q  <= 1'b0;
      to_q   <= 1'b0;
      ito_q  <= 1'b0;
      cont_q <= 1'b0;
      ld_q   <= 1'b0;
    end else begin
      per_q  <= per_d;
      cnt_q  <= cnt_d;
      snap_q <= snap_d;
      run_q  <= run_d;
      to_q   <= to_d;
      ito_q  <= ito_d;
      cont_q <= cont_d;
      ld_q   <= ld_d;
    end
  end

  // Software-visible view of the four registers
  always_comb begin
    rd_o = '0;
    rd_o[REG_STATUS][STAT_TO]   = to_q;
    rd_o[REG_STATUS][STAT_RUN]  = run_q;
    rd_o[REG_CONTROL][CTRL_ITO] = ito_q;
    rd_o[REG_CONTROL][CTRL_CONT] = cont_q;
    rd_o[REG_CONTROL][PRESC_LSB +: PRESC_W] =
      presc_rd;
    rd_o[REG_PERIOD]   = 32'(per_q);
    rd_o[REG_SNAPSHOT] = 32'(snap_q);
  end

  assign irq_o = to_q & ito_q;

endmodule

// File: rtl/nios_multi_timer.sv
// Multi-channel interval timer: bus decode, read mux, irq reduce.
// NIOS_MULTI_TIMER_PRESCALER_EN enables per-channel prescalers.
module nios_multi_timer
  import nios_multi_timer_pkg::*;
#(
  parameter int          NUM_CH     = 4,
  parameter int          COUNT_W    = 32,
  parameter logic [31:0] PERIOD_RST = 32'd99999,
  localparam int         AW         = $clog2(NUM_CH) + 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [AW-1:0]     address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              irq,
  output logic [NUM_CH-1:0] irq_vec
);

  logic [AW-1:0] ch_a;
  logic [1:0]    reg_a;
  logic          wr;
  logic [NUM_CH-1:0][3:0][31:0] rd;
  logic [31:0]   rdata_d, rdata_q;

  assign ch_a  = address >> 2;
  assign reg_a = address[1:0];
  assign wr    = chipselect & ~write_n;

  // Out-of-range channel numbers match no instance
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    nios_multi_timer_ch #(
      .COUNT_W    (COUNT_W),
      .PERIOD_RST (PERIOD_RST)
    ) u_ch (
      .clk     (clk),
      .reset_n (reset_n),
      .we_i    (wr && (ch_a == AW'(i))),
      .reg_i   (reg_a),
      .wdata_i (writedata),
      .irq_o   (irq_vec[i]),
      .rd_o    (rd[i])
    );
  end

  // Read mux; unmatched channels read zero
  always_comb begin
    rdata_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_a == AW'(i))
        rdata_d = rd[i][reg_a];
    end
  end

  // Read data is registered every cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      rdata_q <= '0;
    else
      rdata_q <= rdata_d;
  end

  assign readdata = rdata_q;
  assign irq      = |irq_vec;

endmodule

// File: tb/tb_nios_multi_timer.sv
// Bench for nios_multi_timer: reference model plus directed pins.
// Works with or without NIOS_MULTI_TIMER_PRESCALER_EN.
module tb_nios_multi_timer;

  localparam int NCH = 4;

`ifdef NIOS_MULTI_TIMER_PRESCALER_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [3:0] address = '0;
  logic chipselect = 1'b0;
  logic write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic irq;
  logic [NCH-1:0] irq_vec;

  logic [3:0] a3 = '0;
  logic cs3 = 1'b0;
  logic wn3 = 1'b1;
  logic [31:0] wd3 = '0;
  logic [31:0] rd3;
  logic irq3;
  logic [2:0] iv3;

  always #5 clk = ~clk;

  nios_multi_timer u_dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq),
    .irq_vec    (irq_vec)
  );

  nios_multi_timer #(
    .NUM_CH  (3),
    .COUNT_W (16)
  ) u_dut3 (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (a3),
    .chipselect (cs3),
    .write_n    (wn3),
    .writedata  (wd3),
    .readdata   (rd3),
    .irq        (irq3),
    .irq_vec    (iv3)
  );

  int n_chk = 0;
  int n_fail = 0;

  function automatic void chk(string nm,
                              logic [31:0] act,
                              logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h",
               nm, act, exp);
    end
  endfunction

  // ---------------- reference model ----------------
  int unsigned m_per[NCH];
  int unsigned m_cnt[NCH];
  int unsigned m_snap[NCH];
  int m_presc[NCH];
  int m_pc[NCH];
  bit m_run[NCH];
  bit m_to[NCH];
  bit m_ito[NCH];
  bit m_cont[NCH];
  bit m_ld[NCH];
  logic [31:0] exp_rd = '0;

  function automatic void m_reset();
    for (int c = 0; c < NCH; c++) begin
      m_per[c] = 99999;
      m_cnt[c] = 99999;
      m_snap[c] = 0;
      m_presc[c] = 0;
      m_pc[c] = 0;
      m_run[c] = 0;
      m_to[c] = 0;
      m_ito[c] = 0;
      m_cont[c] = 0;
      m_ld[c] = 0;
    end
    exp_rd = '0;
  endfunction

  function automatic logic [31:0] m_view(int c, int r);
    case (r)
      0: return {30'd0, m_run[c], m_to[c]};
      1: return {16'd0, 8'(m_presc[c]), 6'd0,
                 m_cont[c], m_ito[c]};
      2: return m_per[c];
      default: return m_snap[c];
    endcase
  endfunction

  function automatic logic [NCH-1:0] m_irqv();
    logic [NCH-1:0] v;
    for (int c = 0; c < NCH; c++)
      v[c] = m_to[c] && m_ito[c];
    return v;
  endfunction

  function automatic void m_step();
    bit wr;
    int wc;
    int wrg;
    logic [31:0] d;
    wr = chipselect && !write_n;
    wc = int'(address[3:2]);
    wrg = int'(address[1:0]);
    d = writedata;
    exp_rd = m_view(wc, wrg);
    for (int c = 0; c < NCH; c++) begin
      bit w, tick, expire, start, stop, nrun, nto;
      int unsigned ncnt;
      w = wr && (wc == c);
      tick = PEN ? (m_pc[c] == m_presc[c]) : 1'b1;
      start = w && wrg == 1 && d[2];
      stop = w && wrg == 1 && d[3];
      expire = !m_ld[c] && m_run[c] && tick &&
               m_cnt[c] == 0;
      ncnt = m_cnt[c];
      nrun = m_run[c];
      nto = m_to[c];
      if (m_ld[c]) begin
        ncnt = m_per[c];
        nrun = 0;
      end else if (m_run[c] && tick) begin
        ncnt = expire ? m_per[c] : m_cnt[c] - 1;
      end
      if (expire && !m_cont[c]) nrun = 0;
      if (stop) nrun = 0;
      if (start) nrun = 1;
      if (w && wrg == 0 && d[0]) nto = 0;
      if (expire) nto = 1;
      if (PEN) begin
        if (m_run[c]) m_pc[c] = tick ? 0 : m_pc[c] + 1;
        if (start || m_ld[c] || expire) m_pc[c] = 0;
        if (w && wrg == 1) m_presc[c] = int'(d[15:8]);
      end
      if (w && wrg == 3) m_snap[c] = m_cnt[c];
      if (w && wrg == 1) begin
        m_ito[c] = d[0];
        m_cont[c] = d[1];
      end
      m_cnt[c] = ncnt;
      m_run[c] = nrun;
      m_to[c] = nto;
      if (w && wrg == 2) m_per[c] = d;
      m_ld[c] = w && wrg == 2;
    end
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) m_reset();
    else m_step();
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (reset_n) begin
      chk("readdata", readdata, exp_rd);
      chk("irq_vec", 32'(irq_vec), 32'(m_irqv()));
      chk("irq", 32'(irq), 32'(|m_irqv()));
    end
  end

  // ---------------- bus helpers ----------------
  task automatic bus_wr(input logic [3:0] a,
                        input logic [31:0] d);
    address = a;
    chipselect = 1'b1;
    write_n = 1'b0;
    writedata = d;
    @(negedge clk);
    chipselect = 1'b0;
    write_n = 1'b1;
  endtask

  task automatic bus_rd(input logic [3:0] a,
                        input logic [31:0] e,
                        input string nm);
    address = a;
    chipselect = 1'b1;
    write_n = 1'b1;
    @(negedge clk);
    chk(nm, readdata, e);
    chipselect = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd_all_reset(input string tag);
    for (int c = 0; c < NCH; c++) begin
      bus_rd(4'(c * 4 + 0), 32'd0, {tag, " status"});
      bus_rd(4'(c * 4 + 1), 32'd0, {tag, " control"});
      bus_rd(4'(c * 4 + 2), 32'd99999, {tag, " period"});
      bus_rd(4'(c * 4 + 3), 32'd0, {tag, " snapshot"});
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    chk("reset readdata", readdata, 32'd0);
    chk("reset irq", 32'(irq), 32'd0);
    rd_all_reset("reset");

    // ch0 continuous, period 5, no irq enable
    bus_wr(4'd2, 32'd5);
    bus_wr(4'd1, 32'h6);
    address = 4'd0;
    idle(6);
    chk("ch0 run no to", readdata, 32'h2);
    idle(1);
    chk("ch0 to after 6", readdata, 32'h3);
    chk("ch0 irq masked", 32'(irq), 32'd0);

    // ch2 one-shot, period 3, irq enabled
    bus_wr(4'd10, 32'd3);
    bus_wr(4'd9, 32'h5);
    idle(3);
    chk("ch2 irq_vec early", 32'(irq_vec), 32'd0);
    idle(1);
    chk("ch2 irq_vec", 32'(irq_vec), 32'h4);
    chk("ch2 irq", 32'(irq), 32'd1);
    bus_rd(4'd8, 32'h1, "ch2 status");
    bus_wr(4'd8, 32'h1);
    chk("ch2 irq cleared", 32'(irq), 32'd0);

    // ch1 snapshot of a running count
    bus_wr(4'd6, 32'd1000);
    bus_wr(4'd5, 32'h4);
    idle(9);
    bus_wr(4'd7, 32'hdead_beef);
    bus_rd(4'd7, 32'd991, "ch1 snapshot");
    bus_rd(4'd6, 32'd1000, "ch1 period");

    // ch3 clear on the exact timeout edge
    bus_wr(4'd14, 32'd2);
    bus_wr(4'd13, 32'h6);
    idle(2);
    bus_wr(4'd12, 32'h1);
    bus_rd(4'd12, 32'h3, "ch3 to kept");

    // ch0 prescaler 3, period 2, continuous
    bus_wr(4'd2, 32'd2);
    bus_wr(4'd1, 32'h0306);
    bus_wr(4'd0, 32'h1);
`ifdef NIOS_MULTI_TIMER_PRESCALER_EN
    address = 4'd0;
    idle(11);
    chk("presc no to", readdata, 32'h2);
    idle(1);
    chk("presc to at 12", readdata, 32'h3);
`else
    bus_rd(4'd1, 32'h2, "ctrl presc zero");
`endif

    // out-of-range channel on a 3-channel build
    a3 = 4'd14;
    cs3 = 1'b1;
    wn3 = 1'b0;
    wd3 = 32'h55;
    @(negedge clk);
    a3 = 4'd13;
    wd3 = 32'h7;
    @(negedge clk);
    cs3 = 1'b0;
    wn3 = 1'b1;
    a3 = 4'd14;
    @(negedge clk);
    chk("oor period", rd3, 32'd0);
    a3 = 4'd12;
    @(negedge clk);
    chk("oor status", rd3, 32'd0);
    a3 = 4'd2;
    @(negedge clk);
    chk("dut3 ch0 period", rd3, 32'h869F);
    a3 = 4'd1;
    @(negedge clk);
    chk("dut3 ch0 control", rd3, 32'd0);
    idle(4);
    chk("dut3 irq", 32'(irq3), 32'd0);
    chk("dut3 irq_vec", 32'(iv3), 32'd0);

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      address = 4'($urandom_range(0, 15));
      chipselect = ($urandom_range(0, 3) != 0);
      write_n = ($urandom_range(0, 2) != 0);
      case (address[1:0])
        2'd2: writedata = $urandom_range(0, 9);
        2'd1: writedata = $urandom & 32'hFFF0_03FF;
        default: writedata = $urandom;
      endcase
      @(negedge clk);
    end
    chipselect = 1'b0;
    write_n = 1'b1;

    // all channels counting, then reset mid-count
    for (int c = 0; c < NCH; c++)
      bus_wr(4'(c * 4 + 2), 32'd50);
    for (int c = 0; c < NCH; c++)
      bus_wr(4'(c * 4 + 0), 32'h1);
    for (int c = 0; c < NCH; c++)
      bus_wr(4'(c * 4 + 1), 32'h7);
    idle(20);
    chk("pre-reset irq", 32'(irq), 32'd0);
    bus_rd(4'd0, 32'h2, "pre-reset ch0 run");
    #2;
    reset_n = 1'b0;
    #1;
    chk("async readdata", readdata, 32'd0);
    chk("async irq", 32'(irq), 32'd0);
    chk("async irq_vec", 32'(irq_vec), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    rd_all_reset("post");
    chk("post irq", 32'(irq), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
